ex_multicycle_scheduler: RTL
============================

EX_MULTICYCLE_SCHEDULER -- requirements
Module: ex_multicycle_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, max WAIT cycles before abort; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 idex_valid  input  1  ID/EX holds a live instruction.
REQ-005 idex_unit_req  input  3  one-hot multicycle request: bit0 mul_div, bit1 atomic, bit2 fpu.
REQ-006 idex_rd  input  5  integer destination of EX instruction.
REQ-007 ifid_rs1, ifid_rs2  input  5 each  integer sources of ID instruction.
REQ-008 flush  input  1  later-stage flush; kills EX instruction.
REQ-009 unit_done  input  3  per-unit completion pulse, same bit order as REQ-005.
REQ-010 unit_start  output  3  one-cycle start pulse to selected unit.
REQ-011 unit_abort  output  3  one-cycle kill pulse to in-flight unit.
REQ-012 hold_ex  output  1  hold ID/EX and EX/MEM registers.
REQ-013 stall_front  output  1  stall PC and IF/ID.
REQ-014 bubble_idex  output  1  insert NOP into ID/EX.
REQ-015 busy  output  1  state != IDLE.
REQ-016 timeout_err  output  1  one-cycle pulse on watchdog abort.

Function
REQ-017 States IDLE, WAIT, DRAIN; 2-bit state register; 8-bit watchdog counter; latched unit (3-bit one-hot) and latched rd (5-bit).
REQ-018 Accept (IDLE or DRAIN): idex_valid && idex_unit_req!=0 && !flush -> unit_start = selected bit, combinational same cycle; latch unit and idex_rd; counter <= 0; next WAIT.
REQ-019 Multiple request bits set: priority mul_div > atomic > fpu; only the winner starts.
REQ-020 Accept cycle: hold_ex=1, stall_front=1, bubble_idex=0.
REQ-021 WAIT, latched unit's done=0: hold_ex=1, stall_front=1, counter += 1.
REQ-022 WAIT, latched unit's done=1: hold_ex=0 (instruction advances); hazard = latched_rd!=0 && (latched_rd==ifid_rs1 || latched_rd==ifid_rs2); stall_front=bubble_idex=hazard; next DRAIN if latched_rd!=0, else IDLE.
REQ-023 DRAIN (exactly one cycle): stall_front=bubble_idex=hazard (REQ-022 equation, latched rd); next IDLE unless REQ-018 accepts.
REQ-024 DRAIN accept with hazard=1 is suppressed (bubble wins); the request is re-seen next cycle in IDLE.
REQ-025 unit_done bits not matching latched unit, or arriving in IDLE/DRAIN, are ignored.
REQ-026 flush in WAIT: unit_abort = latched unit for one cycle, hold_ex=0, stall_front=0, next IDLE, no DRAIN; flush beats done in the same cycle.
REQ-027 flush in IDLE/DRAIN: no start, no latch; outputs 0.
REQ-028 Watchdog: WAIT with counter==TIMEOUT_CYCLES-1 and no done -> unit_abort=latched unit, timeout_err=1, hold_ex=0, next IDLE.
REQ-029 Done on the timeout cycle wins over timeout (normal REQ-022 completion).
REQ-030 In IDLE with no request: all outputs 0.
REQ-031 busy asserted in WAIT and DRAIN only.

Reset
REQ-032 reset_n=0 asynchronously: state IDLE, counter 0, latched unit 0, latched rd 0; all outputs 0 while reset asserted.
REQ-033 Reset during WAIT drops in-flight tracking with no abort pulse; the unit is reset by the same reset_n.
REQ-034 First accept possible on the first rising edge after reset_n deasserts.

Verification
REQ-035 mul_div req, idex_rd=5, done 3 cycles after start, ifid_rs1=5 -> start=001 for 1 cycle; hold_ex for 4 cycles; stall+bubble in done cycle and DRAIN cycle.
REQ-036 atomic req, rd=7, ifid rs=3/4, done after 2 cycles -> no bubble; stall_front drops in done cycle; DRAIN then IDLE.
REQ-037 fpu req, rd=0, done -> direct WAIT->IDLE, no DRAIN, no bubble.
REQ-038 TIMEOUT_CYCLES=4, no done -> timeout_err and abort=latched bit on 4th WAIT cycle; hold_ex 0 next.
REQ-039 flush and done same WAIT cycle -> abort pulse, no DRAIN, stall_front=0.
REQ-040 reset_n low mid-WAIT -> all outputs 0 immediately; back-to-back requests with req=011 -> only mul_div starts.

Source files
------------

// File: rtl/ex_multicycle_scheduler.sv
// Execute-stage scheduler for multicycle units (mul_div, atomic, fpu): starts one unit,
// holds the pipeline until it finishes, and guards the result with a watchdog.
module ex_multicycle_scheduler #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       idex_valid,
    input  logic [2:0] idex_unit_req,
    input  logic [4:0] idex_rd,
    input  logic [4:0] ifid_rs1,
    input  logic [4:0] ifid_rs2,
    input  logic       flush,
    input  logic [2:0] unit_done,
    output logic [2:0] unit_start,
    output logic [2:0] unit_abort,
    output logic       hold_ex,
    output logic       stall_front,
    output logic       bubble_idex,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic [2:0] unit_reg, unit_next;
    logic [4:0] rd_reg, rd_next;

    logic [2:0] req_sel;
    logic       accept_req;
    logic       done_hit;
    logic       hazard;

    logic [2:0] start_c, abort_c;
    logic       hold_c, stall_c, bubble_c, terr_c;

    // Fixed priority: mul_div over atomic over fpu.
    always_comb begin
        req_sel = 3'b000;
        if (idex_unit_req[0])      req_sel = 3'b001;
        else if (idex_unit_req[1]) req_sel = 3'b010;
        else if (idex_unit_req[2]) req_sel = 3'b100;
    end

    assign accept_req = idex_valid && (idex_unit_req != 3'b000) && !flush;
    assign done_hit   = |(unit_done & unit_reg);
    assign hazard     = (rd_reg != 5'd0) && ((rd_reg == ifid_rs1) || (rd_reg == ifid_rs2));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 8'd0;
            unit_reg  <= 3'b000;
            rd_reg    <= 5'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            unit_reg  <= unit_next;
            rd_reg    <= rd_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        unit_next  = unit_reg;
        rd_next    = rd_reg;
        start_c    = 3'b000;
        abort_c    = 3'b000;
        hold_c     = 1'b0;
        stall_c    = 1'b0;
        bubble_c   = 1'b0;
        terr_c     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (accept_req) begin
                    start_c    = req_sel;
                    unit_next  = req_sel;
                    rd_next    = idex_rd;
                    cnt_next   = 8'd0;
                    hold_c     = 1'b1;
                    stall_c    = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Flush outranks completion, completion outranks the watchdog.
                if (flush) begin
                    abort_c    = unit_reg;
                    state_next = ST_IDLE;
                end else if (done_hit) begin
                    stall_c    = hazard;
                    bubble_c   = hazard;
                    state_next = (rd_reg != 5'd0) ? ST_DRAIN : ST_IDLE;
                end else if (cnt_reg == TO_LAST) begin
                    abort_c    = unit_reg;
                    terr_c     = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    hold_c   = 1'b1;
                    stall_c  = 1'b1;
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            ST_DRAIN: begin
                state_next = ST_IDLE;
                if (!flush) begin
                    stall_c  = hazard;
                    bubble_c = hazard;
                    // A pending hazard bubble takes precedence; the request is retried from IDLE.
                    if (accept_req && !hazard) begin
                        start_c    = req_sel;
                        unit_next  = req_sel;
                        rd_next    = idex_rd;
                        cnt_next   = 8'd0;
                        hold_c     = 1'b1;
                        stall_c    = 1'b1;
                        state_next = ST_WAIT;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are forced low for as long as reset is held, independent of inputs.
    assign unit_start  = reset_n ? start_c : 3'b000;
    assign unit_abort  = reset_n ? abort_c : 3'b000;
    assign hold_ex     = reset_n && hold_c;
    assign stall_front = reset_n && stall_c;
    assign bubble_idex = reset_n && bubble_c;
    assign timeout_err = reset_n && terr_c;
    assign busy        = reset_n && (state_reg != ST_IDLE);

endmodule
